// File: rtl/binary_to_bcd_pkg.sv
// Shared widths, digit type and the binary-to-BCD conversion helper for the
// binary_to_bcd block.
package binary_bcd_pkg;

    localparam int BIN_W   = 8;
    localparam int DIGIT_W = 4;
    localparam int MAX_DEC = 99;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // Double-dabble over 8 input bits. Returns {tens, ones}. Only meaningful
    // for inputs 0..99; the hundreds digit is computed but discarded.
    function automatic logic [2*DIGIT_W-1:0] bin_to_bcd2(input logic [BIN_W-1:0] b);
        logic [19:0] s;
        s = {12'd0, b};
        for (int i = 0; i < BIN_W; i++) begin
            if (s[11:8] >= 4'd5)  s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return s[15:8];
    endfunction

endpackage

// File: rtl/binary_to_bcd_if.sv
// Bus bundle for binary_to_bcd.
// Handshake: in_valid qualifies x for exactly one cycle and is always accepted
// (no ready/backpressure); out_valid pulses for one cycle per accepted input,
// one cycle later, qualifying tens/ones/range_err (which otherwise hold).
interface binary_to_bcd_if;
    import binary_bcd_pkg::*;

    logic              in_valid;
    logic [BIN_W-1:0]  x;
    logic              out_valid;
    bcd_digit_t        tens;
    bcd_digit_t        ones;
    logic              range_err;
    logic [BIN_W-1:0]  y;

    modport master (
        output in_valid, x,
        input  out_valid, tens, ones, range_err, y
    );

    modport slave (
        input  in_valid, x,
        output out_valid, tens, ones, range_err, y
    );

endinterface

// File: rtl/binary_to_bcd_decoder.sv
// bcd_to_binary: combinational round-trip decode y = tens*10 + ones, truncated
// to 8 bits. Digit values 10..15 are decoded arithmetically with no flagging.
module bcd_to_binary
    import binary_bcd_pkg::*;
(
    input  bcd_digit_t        tens,
    input  bcd_digit_t        ones,
    output logic [BIN_W-1:0]  y
);

    // Multiply-accumulate; max 15*10+15 = 165 so nothing is actually lost.
    always_comb begin
        y = (BIN_W'(tens) * BIN_W'(10)) + BIN_W'(ones);
    end

endmodule

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: 1-cycle-latency, full-throughput binary (0..99) to two-digit
// BCD converter with registered outputs and out-of-range flag.
// Optional feature macro: BINARY_TO_BCD_ROUNDTRIP_EN -- when defined, the
// bcd_to_binary decoder drives y from the registered digits; otherwise y = 0.
module binary_to_bcd
    import binary_bcd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    binary_to_bcd_if.slave  bus
);

    localparam logic [BIN_W-1:0] MAX_DEC_B = BIN_W'(MAX_DEC);

    logic       out_valid_q, out_valid_d;
    bcd_digit_t tens_q, tens_d;
    bcd_digit_t ones_q, ones_d;
    logic       range_err_q, range_err_d;

    // Next-state: convert on a valid input, otherwise hold the last result.
    always_comb begin
        out_valid_d = bus.in_valid;
        tens_d      = tens_q;
        ones_d      = ones_q;
        range_err_d = range_err_q;
        if (bus.in_valid) begin
            if (bus.x > MAX_DEC_B) begin
                tens_d      = '0;
                ones_d      = '0;
                range_err_d = 1'b1;
            end else begin
                {tens_d, ones_d} = bin_to_bcd2(bus.x);
                range_err_d      = 1'b0;
            end
        end
    end

    // Output registers; synchronous reset clears everything, ignoring in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            tens_q      <= '0;
            ones_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            range_err_q <= range_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.tens      = tens_q;
    assign bus.ones      = ones_q;
    assign bus.range_err = range_err_q;

`ifdef BINARY_TO_BCD_ROUNDTRIP_EN
    logic [BIN_W-1:0] y_dec;

    bcd_to_binary u_dec (
        .tens (tens_q),
        .ones (ones_q),
        .y    (y_dec)
    );

    assign bus.y = y_dec;
`else
    assign bus.y = '0;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: scoreboard of expected digit/flag
// tuples pushed on drive and popped when out_valid appears.
module tb_binary_to_bcd;
    import binary_bcd_pkg::*;

    localparam int W = 9;  // {tens[3:0], ones[3:0], range_err}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_to_bcd_if bus_if ();

    binary_to_bcd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [7:0] xv);
        if (xv > 8'd99) return {4'd0, 4'd0, 1'b1};
        return {4'(xv / 10), 4'(xv % 10), 1'b0};
    endfunction

    function automatic logic [31:0] exp_y(input logic [W-1:0] e);
        logic [31:0] v;
        v = 32'(e[8:5]) * 32'd10 + 32'(e[4:1]);
`ifdef BINARY_TO_BCD_ROUNDTRIP_EN
        return v & 32'hFF;
`else
        return v & 32'h0;
`endif
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle of inputs, then check every output just after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] xv);
        rst             = r;
        bus_if.in_valid = v;
        bus_if.x        = xv;
        if (v && !r) exp_q.push_back(model(xv));
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            held = '0;
            check("out_valid_rst", 32'(bus_if.out_valid), 32'd0);
        end else if (v) begin
            check("out_valid_hi", 32'(bus_if.out_valid), 32'd1);
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else held = exp_q.pop_front();
        end else begin
            check("out_valid_lo", 32'(bus_if.out_valid), 32'd0);
        end
        check("tens",      32'(bus_if.tens),      32'(held[8:5]));
        check("ones",      32'(bus_if.ones),      32'(held[4:1]));
        check("range_err", 32'(bus_if.range_err), 32'(held[0]));
        check("y",         32'(bus_if.y),         exp_y(held));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        held            = '0;
        bus_if.in_valid = 1'b0;
        bus_if.x        = '0;

        // Reset for two cycles, with a valid input that must be ignored.
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd57);

        // Basic vectors.
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 8'd57);
        step(1'b0, 1'b1, 8'd99);

        // Back-to-back sweep 0..99.
        for (int i = 0; i <= 99; i++) step(1'b0, 1'b1, 8'(i));

        // Out of range boundaries.
        step(1'b0, 1'b1, 8'd100);
        step(1'b0, 1'b1, 8'd255);
        step(1'b0, 1'b1, 8'd98);

        // Hold behaviour, then reset during the hold.
        step(1'b0, 1'b1, 8'd42);
        step(1'b0, 1'b0, 8'd7);
        step(1'b0, 1'b0, 8'd200);
        step(1'b0, 1'b0, 8'd13);
        step(1'b1, 1'b1, 8'd88);
        step(1'b0, 1'b0, 8'd0);

        // Input accepted right before reset is discarded.
        step(1'b0, 1'b1, 8'd33);
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);

        // Random traffic with gaps and out-of-range values.
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));

        // Final vector.
        step(1'b0, 1'b1, 8'd73);
        step(1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
